bcd_counter_3d: RTL and testbench

BCD_COUNTER_3D -- requirements
Module: bcd_counter_3d

---
 rtl/bcd_counter_3d_if.sv | 32 +++
 rtl/bcd_counter_3d.sv | 133 +++++++++++++
 tb/tb_bcd_counter_3d.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_3d_if.sv
// Bus bundle for the 3-digit BCD counter.
// Ports (from the counter's point of view):
//   btn_in   in   raw asynchronous push-button, high = pressed
//   up_dn    in   count direction, 1 = up, 0 = down
//   clr      in   synchronous clear of the count to 000
//   load     in   synchronous load of load_val
//   load_val in   12-bit BCD {d2,d1,d0}
//   auto_en  in   enable for the prescaled auto-count
//   digits   out  registered BCD count {d2,d1,d0}
//   wrap     out  one-cycle pulse on 999->000 / 000->999
//   upd      out  one-cycle pulse whenever digits is written
interface bcd_counter_3d_if;
  logic        btn_in;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [11:0] load_val;
  logic        auto_en;
  logic [11:0] digits;
  logic        wrap;
  logic        upd;

  modport master (
    output btn_in, up_dn, clr, load, load_val, auto_en,
    input  digits, wrap, upd
  );

  modport slave (
    input  btn_in, up_dn, clr, load, load_val, auto_en,
    output digits, wrap, upd
  );
endinterface

// File: rtl/bcd_counter_3d.sv
// Three-digit BCD up/down counter stepped by a debounced push-button and/or
// a prescaled auto-count tick, with synchronous clear and load.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  bcd_counter_3d_if.slave (button, direction, clr/load, auto_en in;
//        digits, wrap, upd out)
// Parameters:
//   DB_CYCLES  consecutive clocks the synchronized button must differ from
//              the debounced state before that state changes (2..65535)
//   AUTO_DIV   clocks per auto-count tick (2..2^20)
module bcd_counter_3d #(
  parameter int DB_CYCLES = 16,
  parameter int AUTO_DIV  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  bcd_counter_3d_if.slave  bus
);

  localparam int              PW       = $clog2(AUTO_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(AUTO_DIV - 1);
  localparam logic [15:0]     DB_LAST  = 16'(DB_CYCLES - 1);

  // One BCD step; bit 12 is the carry/borrow out of the top digit (wrap).
  function automatic logic [12:0] bcd_step(input logic [11:0] v, input logic up);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (up) begin
          if (v[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  // Saturate each loaded digit to 9 so digits stays valid BCD.
  function automatic logic [11:0] bcd_sat(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  logic          r_s1, r_s2, r_db, r_press;
  logic [15:0]   r_db_cnt;
  logic [PW-1:0] r_pre;
  logic [11:0]   r_digits;
  logic          r_wrap, r_upd;

  logic          w_tick, w_step, w_db_hit;
  logic [12:0]   w_bcd;
  logic [11:0]   w_digits_nx;
  logic          w_wrap_nx, w_upd_nx;
  logic [PW-1:0] w_pre_nx;

  always_comb begin
    w_tick      = bus.auto_en && (r_pre == PRE_LAST);
    w_step      = r_press || w_tick;
    w_db_hit    = (r_s2 != r_db) && (r_db_cnt == DB_LAST);
    w_bcd       = bcd_step(r_digits, bus.up_dn);
    w_digits_nx = r_digits;
    w_wrap_nx   = 1'b0;
    w_upd_nx    = 1'b0;
    // clr > load > step; a coincident press/tick is simply dropped.
    if (bus.clr) begin
      w_digits_nx = 12'h000;
      w_upd_nx    = 1'b1;
    end else if (bus.load) begin
      w_digits_nx = bcd_sat(bus.load_val);
      w_upd_nx    = 1'b1;
    end else if (w_step) begin
      w_digits_nx = w_bcd[11:0];
      w_wrap_nx   = w_bcd[12];
      w_upd_nx    = 1'b1;
    end
    if (bus.clr || !bus.auto_en || (r_pre == PRE_LAST)) w_pre_nx = '0;
    else                                                w_pre_nx = r_pre + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_db     <= 1'b0;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
      r_pre    <= '0;
      r_digits <= 12'h000;
      r_wrap   <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      // Two-flop synchronizer for the asynchronous button.
      r_s1 <= bus.btn_in;
      r_s2 <= r_s1;
      // Debounce: count consecutive disagreeing clocks; flip db on the clock
      // the count would reach DB_CYCLES. Only a 0->1 flip is a press.
      r_press <= 1'b0;
      if (r_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (w_db_hit) begin
        r_db     <= r_s2;
        r_db_cnt <= '0;
        r_press  <= r_s2;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
      r_pre    <= w_pre_nx;
      r_digits <= w_digits_nx;
      r_wrap   <= w_wrap_nx;
      r_upd    <= w_upd_nx;
    end
  end

  assign bus.digits = r_digits;
  assign bus.wrap   = r_wrap;
  assign bus.upd    = r_upd;

endmodule

// File: tb/tb_bcd_counter_3d.sv
// Bench for bcd_counter_3d with DB_CYCLES=4, AUTO_DIV=10: directed edge-exact
// scenarios followed by randomized stimulus, all checked every cycle against
// an integer-valued behavioural model.
module tb_bcd_counter_3d;
  localparam int DB = 4;
  localparam int AD = 10;

  logic clk = 1'b0;
  logic rst;
  bcd_counter_3d_if bus ();

  bcd_counter_3d #(.DB_CYCLES(DB), .AUTO_DIV(AD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural model: count kept as an integer 0..999.
  int m_val = 0;
  bit m_wrap = 0, m_upd = 0;
  bit m_s1 = 0, m_s2 = 0, m_db = 0, m_press = 0;
  int m_run = 0, m_pre = 0;

  always @(posedge clk) begin : model
    bit tick, step, n_press;
    if (rst) begin
      m_val = 0; m_wrap = 0; m_upd = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0;
      m_run = 0; m_pre = 0;
    end else begin
      tick = bus.auto_en && (m_pre == AD - 1);
      step = m_press || tick;
      m_wrap = 0;
      m_upd  = 0;
      if (bus.clr) begin
        m_val = 0; m_upd = 1;
      end else if (bus.load) begin
        m_val = 100 * lim(bus.load_val[11:8]) + 10 * lim(bus.load_val[7:4]) + lim(bus.load_val[3:0]);
        m_upd = 1;
      end else if (step) begin
        m_upd = 1;
        if (bus.up_dn) begin
          m_wrap = (m_val == 999);
          m_val  = (m_val + 1) % 1000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 999) % 1000;
        end
      end
      m_pre = (bus.clr || !bus.auto_en) ? 0 : (m_pre + 1) % AD;
      n_press = 0;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db = m_s2; m_run = 0; n_press = m_s2;
        end
      end else begin
        m_run = 0;
      end
      m_press = n_press;
      m_s2 = m_s1;
      m_s1 = bus.btn_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_digits", 32'(bus.digits), 32'(to_bcd(m_val)));
      chk("model_wrap",   32'(bus.wrap),   32'(m_wrap));
      chk("model_upd",    32'(bus.upd),    32'(m_upd));
    end
  end

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_n(1);
    rst = 1'b0;
  endtask

  initial begin
    int upd_seen;
    int hold;
    rst = 1'b1;
    bus.btn_in = 0; bus.up_dn = 1; bus.clr = 0; bus.load = 0;
    bus.load_val = 12'h000; bus.auto_en = 0;
    step_n(1);
    cmp_on = 1'b1;
    chk("reset_digits", 32'(bus.digits), 32'h000);
    chk("reset_wrap",   32'(bus.wrap),   32'h0);
    chk("reset_upd",    32'(bus.upd),    32'h0);
    rst = 1'b0;

    // Held press: one step exactly 7 edges after reset release.
    rst = 1'b1; bus.btn_in = 1;
    step_n(1);
    rst = 1'b0;
    step_n(6);
    chk("press_before", 32'(bus.digits), 32'h000);
    step_n(1);
    chk("press_edge7", 32'(bus.digits), 32'h001);
    chk("press_upd",   32'(bus.upd),    32'h1);
    step_n(1);
    chk("press_upd_off", 32'(bus.upd), 32'h0);
    step_n(12);
    bus.btn_in = 0;
    step_n(10);
    chk("press_hold_release", 32'(bus.digits), 32'h001);

    // Short glitch: no event.
    do_reset();
    bus.btn_in = 1;
    step_n(3);
    bus.btn_in = 0;
    upd_seen = 0;
    repeat (15) begin
      step_n(1);
      upd_seen += int'(bus.upd);
    end
    chk("glitch_upd_count", 32'(upd_seen), 32'd0);
    chk("glitch_digits", 32'(bus.digits), 32'h000);

    // Load 998 then auto-count up.
    do_reset();
    bus.load_val = 12'h998; bus.load = 1;
    step_n(1);
    chk("load_998", 32'(bus.digits), 32'h998);
    bus.load = 0; bus.auto_en = 1; bus.up_dn = 1;
    step_n(9);
    chk("auto_edge9", 32'(bus.digits), 32'h998);
    step_n(1);
    chk("auto_edge10", 32'(bus.digits), 32'h999);
    chk("auto_edge10_wrap", 32'(bus.wrap), 32'h0);
    step_n(10);
    chk("auto_edge20", 32'(bus.digits), 32'h000);
    chk("auto_edge20_wrap", 32'(bus.wrap), 32'h1);
    bus.auto_en = 0;
    step_n(1);
    chk("auto_wrap_off", 32'(bus.wrap), 32'h0);

    // Down press from 000 wraps to 999.
    do_reset();
    bus.up_dn = 0; bus.btn_in = 1;
    step_n(6);
    chk("down_before", 32'(bus.digits), 32'h000);
    step_n(1);
    chk("down_999",  32'(bus.digits), 32'h999);
    chk("down_wrap", 32'(bus.wrap),   32'h1);
    chk("down_upd",  32'(bus.upd),    32'h1);
    step_n(1);
    chk("down_wrap_off", 32'(bus.wrap), 32'h0);
    chk("down_upd_off",  32'(bus.upd),  32'h0);
    chk("down_hold",     32'(bus.digits), 32'h999);
    bus.btn_in = 0;
    step_n(8);

    // Saturating load, then clr beats load.
    bus.load_val = 12'h1A5; bus.load = 1;
    step_n(1);
    chk("sat_load", 32'(bus.digits), 32'h195);
    bus.clr = 1;
    step_n(1);
    chk("clr_load_digits", 32'(bus.digits), 32'h000);
    chk("clr_load_upd",    32'(bus.upd),    32'h1);
    chk("clr_load_wrap",   32'(bus.wrap),   32'h0);
    bus.clr = 0; bus.load = 0; bus.up_dn = 1;

    // Reset mid-debounce: partial count discarded.
    do_reset();
    bus.btn_in = 1;
    step_n(4);
    rst = 1'b1;
    step_n(1);
    rst = 1'b0;
    chk("midrst_digits", 32'(bus.digits), 32'h000);
    step_n(6);
    chk("midrst_before", 32'(bus.digits), 32'h000);
    step_n(1);
    chk("midrst_edge7", 32'(bus.digits), 32'h001);
    bus.btn_in = 0;
    step_n(8);

    // Randomized phase.
    bus.auto_en = 1;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        bus.btn_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      bus.up_dn    = 1'($urandom_range(0, 1));
      bus.clr      = ($urandom_range(0, 59) == 0);
      bus.load     = ($urandom_range(0, 39) == 0);
      bus.load_val = 12'($urandom);
      if ($urandom_range(0, 99) == 0) bus.auto_en = ~bus.auto_en;
      rst = ($urandom_range(0, 399) == 0);
      step_n(1);
    end
    rst = 1'b0;
    step_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
